ex_mem_skid_stage: RTL

//  EX->MEM pipeline stage directly downstream of the 32-bit ALU.

---
 rtl/ex_mem_skid_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage: two-entry skid buffer (main + skid) with a registered in_ready.
// Optional stall counter output enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_skid_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_wreg,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_wreg,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_d;
    logic              r_in_ready;
    logic              w_in_ready_d;

    logic [DATA_W-1:0] r_main_alu;
    logic              r_main_zero;
    logic [DATA_W-1:0] r_main_wdata;
    logic [REG_W-1:0]  r_main_wreg;
    logic [CTRL_W-1:0] r_main_ctrl;

    logic [DATA_W-1:0] r_skid_alu;
    logic              r_skid_zero;
    logic [DATA_W-1:0] r_skid_wdata;
    logic [REG_W-1:0]  r_skid_wreg;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    assign out_valid  = (r_state != ST_EMPTY);
    assign in_ready   = r_in_ready;
    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_d        = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_d = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_d      = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_d = ST_EMPTY;
                    end else if (w_in_xfer) begin
                        w_state_d   = ST_TWO;
                        w_load_skid = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        w_state_d        = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_d = ST_EMPTY;
            endcase
        end
        // in_ready is a function of the next state so it stays a plain flop output
        w_in_ready_d = (w_state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_in_ready <= w_in_ready_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_alu   <= '0;
            r_main_zero  <= 1'b0;
            r_main_wdata <= '0;
            r_main_wreg  <= '0;
            r_main_ctrl  <= '0;
        end else if (flush) begin
            r_main_alu   <= '0;
            r_main_zero  <= 1'b0;
            r_main_wdata <= '0;
            r_main_wreg  <= '0;
            r_main_ctrl  <= '0;
        end else if (w_load_main_in) begin
            r_main_alu   <= in_alu_result;
            r_main_zero  <= in_zero;
            r_main_wdata <= in_wdata;
            r_main_wreg  <= in_wreg;
            r_main_ctrl  <= in_ctrl;
        end else if (w_load_main_skid) begin
            r_main_alu   <= r_skid_alu;
            r_main_zero  <= r_skid_zero;
            r_main_wdata <= r_skid_wdata;
            r_main_wreg  <= r_skid_wreg;
            r_main_ctrl  <= r_skid_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_alu   <= '0;
            r_skid_zero  <= 1'b0;
            r_skid_wdata <= '0;
            r_skid_wreg  <= '0;
            r_skid_ctrl  <= '0;
        end else if (flush) begin
            r_skid_alu   <= '0;
            r_skid_zero  <= 1'b0;
            r_skid_wdata <= '0;
            r_skid_wreg  <= '0;
            r_skid_ctrl  <= '0;
        end else if (w_load_skid) begin
            r_skid_alu   <= in_alu_result;
            r_skid_zero  <= in_zero;
            r_skid_wdata <= in_wdata;
            r_skid_wreg  <= in_wreg;
            r_skid_ctrl  <= in_ctrl;
        end
    end

    assign out_alu_result = r_main_alu;
    assign out_zero       = r_main_zero;
    assign out_wdata      = r_main_wdata;
    assign out_wreg       = r_main_wreg;
    assign out_ctrl       = r_main_ctrl;

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Counts MEM-side stalls; survives flush so it reflects total stall history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
